// File: rtl/fpu_wb_bridge.sv
// ---------------------------------------------------------------------------
// fpu_wb_bridge
//
// Wishbone classic slave that exposes the FPU register file through a
// word-addressed window at BASE_ADDR .. BASE_ADDR+LAST_OFF.
//
// Every request runs the same three-state sequence IDLE -> ACCESS -> RESP, so
// a transaction occupies exactly three cycles.  The register-file address bus
// is parked at zero outside the single ACCESS cycle of a valid request,
// because any read-address cycle on the FPU side clears its interrupt flag.
//
// Optional feature (macro FPU_WB_ERR_EN):
//   defined   - invalid requests complete with wbs_err_o=1, wbs_ack_o=0
//   undefined - invalid requests complete with wbs_ack_o=1, wbs_err_o tied 0
//   In both builds an invalid request returns data 0 and never touches the
//   register file.
//
// Ports
//   clk, rst_l           single rising-edge clock, synchronous active-low reset
//   wbs_cyc_i/stb_i/we_i Wishbone controls
//   wbs_sel_i[3:0]       byte selects (writes must use all four)
//   wbs_adr_i, wbs_dat_i address and write data
//   wbs_ack_o, wbs_err_o Wishbone terminations
//   wbs_dat_o            read data
//   reg_addr, reg_wren   register-file address / write enable
//   reg_wrdata           register-file write data
//   reg_rddata           combinational register-file read data
//   inter_gen            operation-done flag; irq is its one-cycle delayed copy
// ---------------------------------------------------------------------------
module fpu_wb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [7:0]  LAST_OFF  = 8'h28
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] reg_addr,
  output logic        reg_wren,
  output logic [31:0] reg_wrdata,
  input  logic [31:0] reg_rddata,
  input  logic        inter_gen,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        valid_q, valid_d;
  logic [31:0] reg_addr_q, reg_addr_d;
  logic        reg_wren_q, reg_wren_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic [31:0] dat_q, dat_d;
  logic        ack_q, ack_d;
  logic        irq_q;
  logic        accept_s;
  logic        req_ok_s;

  // Address/select legality of a request: inside the window, word aligned,
  // not the reserved 0x18 slot, and full-word selects for writes.
  function automatic logic req_legal(input logic [31:0] adr,
                                     input logic        we,
                                     input logic [3:0]  sel);
    req_legal = (adr[31:8] == BASE_ADDR[31:8]) &&
                (adr[1:0] == 2'b00) &&
                (adr[7:0] <= LAST_OFF) &&
                (adr[7:0] != 8'h18) &&
                ((we == 1'b0) || (sel == 4'hF));
  endfunction

  assign accept_s = (state_q == IDLE) && wbs_cyc_i && wbs_stb_i;
  assign req_ok_s = req_legal(wbs_adr_i, wbs_we_i, wbs_sel_i);

`ifdef FPU_WB_ERR_EN
  logic err_q, err_d;
`endif

  // State and output registers; synchronous reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      valid_q    <= 1'b0;
      reg_addr_q <= 32'h0;
      reg_wren_q <= 1'b0;
      wrdata_q   <= 32'h0;
      dat_q      <= 32'h0;
      ack_q      <= 1'b0;
      irq_q      <= 1'b0;
`ifdef FPU_WB_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      valid_q    <= valid_d;
      reg_addr_q <= reg_addr_d;
      reg_wren_q <= reg_wren_d;
      wrdata_q   <= wrdata_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
      irq_q      <= inter_gen;
`ifdef FPU_WB_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  // Next-state logic: requests are only sampled in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs for each state.
  always_comb begin
    we_d       = we_q;
    valid_d    = valid_q;
    wrdata_d   = wrdata_q;
    dat_d      = dat_q;
    reg_addr_d = 32'h0;
    reg_wren_d = 1'b0;
    ack_d      = 1'b0;
`ifdef FPU_WB_ERR_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          we_d     = wbs_we_i;
          valid_d  = req_ok_s;
          wrdata_d = wbs_dat_i;
          // The address is presented during the ACCESS cycle only.
          if (req_ok_s) begin
            reg_addr_d = wbs_adr_i;
            reg_wren_d = wbs_we_i;
          end else begin
            reg_addr_d = 32'h0;
            reg_wren_d = 1'b0;
          end
        end else begin
          we_d = we_q;
        end
      end
      ACCESS: begin
        if (valid_q && !we_q) begin
          dat_d = reg_rddata;
        end else begin
          dat_d = 32'h0;
        end
        // A master that already dropped cyc gets no termination.
        if (wbs_cyc_i) begin
`ifdef FPU_WB_ERR_EN
          if (valid_q) begin
            ack_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
`else
          ack_d = 1'b1;
`endif
        end else begin
          ack_d = 1'b0;
        end
      end
      RESP: begin
        ack_d = 1'b0;
      end
      default: begin
        ack_d = 1'b0;
      end
    endcase
  end

  // Terminations are also withdrawn if the master drops cyc inside RESP or
  // reset is asserted there.
  assign wbs_ack_o  = ack_q & wbs_cyc_i & rst_l;
`ifdef FPU_WB_ERR_EN
  assign wbs_err_o  = err_q & wbs_cyc_i & rst_l;
`else
  assign wbs_err_o  = 1'b0;
`endif
  assign wbs_dat_o  = dat_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wren   = reg_wren_q;
  assign reg_wrdata = wrdata_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_fpu_wb_bridge.sv
module tb_fpu_wb_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] HI   = 32'h3000_0028;
`ifdef FPU_WB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_l;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        wbs_ack_o, wbs_err_o;
  logic [31:0] wbs_dat_o, reg_addr, reg_wrdata, reg_rddata;
  logic        reg_wren, ig, irq, ig_set;

  int errs = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  fpu_wb_bridge dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_err_o  (wbs_err_o),
    .wbs_dat_o  (wbs_dat_o),
    .reg_addr   (reg_addr),
    .reg_wren   (reg_wren),
    .reg_wrdata (reg_wrdata),
    .reg_rddata (reg_rddata),
    .inter_gen  (ig),
    .irq        (irq)
  );

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Register-file stand-in: words at offset>>2, 0x14 reads the done flag,
  // 0x24 (frm) powers up as 2, a read-address cycle on 0x14 clears the flag.
  logic [31:0] mem_s [16];
  always_comb begin
    reg_rddata = mem_s[reg_addr[5:2]];
    if (reg_addr[7:0] == 8'h14) reg_rddata = {31'b0, ig};
  end

  always @(posedge clk) begin
    if (!rst_l) begin
      for (int i = 0; i < 16; i++) mem_s[i] <= 32'h0;
      mem_s[9] <= 32'h2;
      ig <= 1'b0;
    end else begin
      if (reg_wren) mem_s[reg_addr[5:2]] <= reg_wrdata;
      if (ig_set) ig <= 1'b1;
      else if (reg_addr == 32'h3000_0014 && !reg_wren) ig <= 1'b0;
    end
  end

  // Legality of a request from the window arithmetic.
  function automatic logic vf(input logic [31:0] a, input logic w, input logic [3:0] s);
    vf = (a >= BASE) && (a <= HI) && (a % 32'd4 == 32'd0) &&
         (a != BASE + 32'h18) && (!w || s == 4'hF);
  endfunction

  // Transaction model: age counts cycles since acceptance (0 = no transaction).
  int          age;
  logic [31:0] t_adr, t_dat, e_addr, e_wrdata, e_dat;
  logic        t_we, t_ok, t_cyc, e_wren, e_irq;
  logic [31:0] mem_m [16];
  logic        exp_ack, exp_err;

  always @(posedge clk) begin
    if (!rst_l) begin
      age <= 0; e_addr <= 32'h0; e_wren <= 1'b0; e_wrdata <= 32'h0;
      e_dat <= 32'h0; e_irq <= 1'b0; t_ok <= 1'b0; t_cyc <= 1'b0;
      for (int i = 0; i < 16; i++) mem_m[i] <= 32'h0;
      mem_m[9] <= 32'h2;
    end else begin
      e_irq <= ig;
      e_addr <= 32'h0;
      e_wren <= 1'b0;
      if (age == 0) begin
        if (cyc && stb) begin
          age <= 1; t_adr <= adr; t_we <= we; t_dat <= wdat; e_wrdata <= wdat;
          t_ok <= vf(adr, we, sel);
          if (vf(adr, we, sel)) begin
            e_addr <= adr; e_wren <= we;
          end
        end
      end else if (age == 1) begin
        age <= 2;
        t_cyc <= cyc;
        if (t_ok && !t_we)
          e_dat <= (t_adr[7:0] == 8'h14) ? {31'b0, ig} : mem_m[t_adr[5:2]];
        else
          e_dat <= 32'h0;
        if (t_ok && t_we) mem_m[t_adr[5:2]] <= t_dat;
      end else begin
        age <= 0;
      end
    end
  end

  always_comb begin
    exp_ack = (age == 2) && t_cyc && cyc && rst_l && (t_ok || !ERR_EN);
    exp_err = (age == 2) && t_cyc && cyc && rst_l && !t_ok && ERR_EN;
  end

  int cyc_n = 0, wren_cnt = 0, addr_cnt = 0, resp_cnt = 0;
  logic [31:0] last_wren_addr = 32'h0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk32("reg_addr", reg_addr, e_addr);
      chk1("reg_wren", reg_wren, e_wren);
      chk32("reg_wrdata", reg_wrdata, e_wrdata);
      chk1("ack", wbs_ack_o, exp_ack);
      chk1("err", wbs_err_o, exp_err);
      chk1("ack_err_excl", wbs_ack_o & wbs_err_o, 1'b0);
      chk1("irq", irq, e_irq);
      if (wbs_ack_o || wbs_err_o) chk32("dat_o", wbs_dat_o, e_dat);
      if (reg_wren) begin
        wren_cnt <= wren_cnt + 1;
        last_wren_addr <= reg_addr;
      end
      if (reg_addr != 32'h0) addr_cnt <= addr_cnt + 1;
      if (wbs_ack_o || wbs_err_o) resp_cnt <= resp_cnt + 1;
    end
  end

  task automatic wait_resp(output int n, output logic [31:0] d, output logic a, output logic e);
    n = 0; d = 32'h0; a = 1'b0; e = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (wbs_ack_o || wbs_err_o) begin
        n = i; a = wbs_ack_o; e = wbs_err_o; d = wbs_dat_o;
        break;
      end
    end
    if (n == 0) begin
      checks++; errs++;
      $display("FAIL resp_timeout: got no termination within 8 cycles, required one");
    end
  endtask

  task automatic txn(input logic w, input logic [31:0] a_in, input logic [31:0] d_in,
                     input logic [3:0] s, output int n, output logic [31:0] d,
                     output logic a, output logic e);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a_in; wdat = d_in; sel = s;
    wait_resp(n, d, a, e);
  endtask

  task automatic idle_bus();
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  typedef struct { logic w; logic [31:0] a; logic [3:0] s; } bad_t;
  bad_t bad [6];

  initial begin
    int n, w0, a0, r0, t0;
    logic [31:0] d;
    logic ak, er;

    bad[0] = '{1'b0, 32'h3000_0018, 4'hF};
    bad[1] = '{1'b1, 32'h3000_0004, 4'h3};
    bad[2] = '{1'b0, 32'h3000_002C, 4'hF};
    bad[3] = '{1'b0, 32'h3100_0008, 4'hF};
    bad[4] = '{1'b0, 32'h3000_0002, 4'hF};
    bad[5] = '{1'b1, 32'h3000_0018, 4'hF};

    rst_l = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; wdat = 32'h0; ig_set = 1'b0;
    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    chk1("rst_ack", wbs_ack_o, 1'b0);
    chk1("rst_err", wbs_err_o, 1'b0);
    chk32("rst_dat", wbs_dat_o, 32'h0);
    chk32("rst_reg_addr", reg_addr, 32'h0);
    chk1("rst_reg_wren", reg_wren, 1'b0);
    chk32("rst_reg_wrdata", reg_wrdata, 32'h0);
    chk1("rst_irq", irq, 1'b0);
    rst_l = 1'b1;

    // Full-word write to offset 0.
    w0 = wren_cnt;
    txn(1'b1, 32'h3000_0000, 32'h3F80_0000, 4'hF, n, d, ak, er);
    chkn("wr0_latency", n, 3);
    chk1("wr0_ack", ak, 1'b1);
    idle_bus();
    chkn("wr0_wren_pulses", wren_cnt - w0, 1);
    chk32("wr0_wren_addr", last_wren_addr, 32'h3000_0000);

    txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, n, d, ak, er);
    chk32("rd0_data", d, 32'h3F80_0000);
    idle_bus();

    // Status read with the done flag set.
    @(posedge clk); #1 ig_set = 1'b1;
    @(posedge clk); #1 ig_set = 1'b0;
    a0 = addr_cnt;
    txn(1'b0, 32'h3000_0014, 32'h0, 4'hF, n, d, ak, er);
    chk32("rd14_data", d, 32'h1);
    idle_bus();
    chkn("rd14_addr_cycles", addr_cnt - a0, 1);
    repeat (2) @(negedge clk);
    chk1("irq_cleared", irq, 1'b0);

    // Illegal requests.
    foreach (bad[i]) begin
      w0 = wren_cnt; a0 = addr_cnt;
      txn(bad[i].w, bad[i].a, 32'hDEAD_BEEF, bad[i].s, n, d, ak, er);
      chk1("bad_ack", ak, !ERR_EN);
      chk1("bad_err", er, ERR_EN);
      chk32("bad_data", d, 32'h0);
      idle_bus();
      chkn("bad_no_wren", wren_cnt - w0, 0);
      chkn("bad_no_addr", addr_cnt - a0, 0);
    end

    // Highest valid offset.
    txn(1'b1, 32'h3000_0028, 32'h1234_5678, 4'hF, n, d, ak, er);
    idle_bus();
    txn(1'b0, 32'h3000_0028, 32'h0, 4'hF, n, d, ak, er);
    chk32("rd28_data", d, 32'h1234_5678);
    idle_bus();

    // Master abandons a write during ACCESS.
    w0 = wren_cnt; r0 = resp_cnt;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_000C; wdat = 32'hCAFE_0001; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (4) @(posedge clk);
    chkn("drop_acc_no_resp", resp_cnt - r0, 0);
    chkn("drop_acc_wren", wren_cnt - w0, 1);
    txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, n, d, ak, er);
    chkn("after_drop_latency", n, 3);
    chk32("after_drop_data", d, 32'hCAFE_0001);
    idle_bus();

    // Master abandons a read during RESP.
    r0 = resp_cnt;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_000C;
    @(posedge clk);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    chkn("drop_resp_no_resp", resp_cnt - r0, 0);

    // Back-to-back write then read with stb held.
    txn(1'b1, 32'h3000_0008, 32'hAAAA_5555, 4'hF, n, d, ak, er);
    t0 = cyc_n;
    txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, n, d, ak, er);
    chkn("b2b_spacing", cyc_n - t0, 3);
    chk32("b2b_data", d, 32'hAAAA_5555);
    idle_bus();

    // Reset during RESP of a read, then a read on the first edge after release.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0008; sel = 4'hF;
    @(posedge clk);
    @(posedge clk); #1 rst_l = 1'b0;
    @(negedge clk);
    chk1("rstresp_ack", wbs_ack_o, 1'b0);
    @(posedge clk); #1;
    rst_l = 1'b1; adr = 32'h3000_0024;
    @(negedge clk);
    chk1("post_rst_ack", wbs_ack_o, 1'b0);
    chk32("post_rst_dat", wbs_dat_o, 32'h0);
    chk32("post_rst_addr", reg_addr, 32'h0);
    chk1("post_rst_wren", reg_wren, 1'b0);
    chk32("post_rst_wrdata", reg_wrdata, 32'h0);
    chk1("post_rst_irq", irq, 1'b0);
    wait_resp(n, d, ak, er);
    chkn("frm_latency", n, 2);
    chk32("frm_data", d, 32'h2);
    idle_bus();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
